// File: rtl/clk_div_monitor.sv
// Half-cycle resolution monitor for divided clocks: measures period and high time of div_in,
// flags matches against the expected shape and reports lock / timeout.
`timescale 1ns/1ps
module clk_div_monitor #(
  parameter int unsigned CW         = 8,
  parameter int unsigned EXP_PERIOD = 6,
  parameter int unsigned EXP_HIGH   = 3,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          div_in,
  output logic [CW-1:0] period_hc,
  output logic [CW-1:0] high_hc,
  output logic          meas_valid,
  output logic          match,
  output logic          locked,
  output logic          timeout
);

  localparam int unsigned XW = CW + 1;
  localparam int unsigned RW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Clamp a one-bit-wider sum to the hc counter range.
  function automatic logic [CW-1:0] sat_cw(input logic [XW-1:0] v);
    return v[CW] ? CNT_MAX : v[CW-1:0];
  endfunction

  logic          s_n_q;
  logic          h0_q, h1_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          armed_q, armed_d;
  logic [RW-1:0] run_q, run_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          mv_q, mv_d;
  logic          match_q, match_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;

  logic          rise0, rise1, fall0, fall1;
  logic [XW-1:0] cnt_x1, cnt_x2;
  logic [CW-1:0] meas_period, meas_high;
  logic          is_match;

  // Negedge half-sample of div_in.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) s_n_q <= 1'b0;
    else        s_n_q <= div_in;
  end

  // Pair capture at posedge; prev resets high so a level already high is not a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h0_q   <= 1'b1;
      h1_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      h0_q   <= s_n_q;
      h1_q   <= div_in;
      prev_q <= h1_q;
    end
  end

  assign rise0  = !prev_q & h0_q;
  assign rise1  = !h0_q & h1_q;
  assign fall0  = prev_q & !h0_q;
  assign fall1  = h0_q & !h1_q;
  assign cnt_x1 = {1'b0, cnt_q} + XW'(1);
  assign cnt_x2 = {1'b0, cnt_q} + XW'(2);

  always_comb begin
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    armed_d     = armed_q;
    run_d       = run_q;
    period_d    = period_q;
    high_d      = high_q;
    mv_d        = 1'b0;
    match_d     = match_q;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    meas_period = '0;
    meas_high   = '0;
    is_match    = 1'b0;

    if (fall0)               pend_d = sat_cw(cnt_x1);
    else if (fall1 && !rise0) pend_d = sat_cw(cnt_x2);

    // A fall after rise0 belongs to the next period; a fall before rise1 closes this one.
    if (rise0) begin
      meas_period = sat_cw(cnt_x1);
      meas_high   = pend_q;
      cnt_d       = CW'(1);
      if (fall1) pend_d = CW'(1);
    end else if (rise1) begin
      meas_period = sat_cw(cnt_x2);
      meas_high   = pend_d;
      cnt_d       = '0;
    end else begin
      cnt_d = sat_cw(cnt_x2);
    end

    is_match = (meas_period == CW'(EXP_PERIOD)) && (meas_high == CW'(EXP_HIGH));

    if (rise0 || rise1) begin
      if (armed_q) begin
        period_d = meas_period;
        high_d   = meas_high;
        mv_d     = 1'b1;
        match_d  = is_match;
        if (is_match) begin
          run_d    = (run_q == RW'(LOCK_CNT)) ? run_q : run_q + RW'(1);
          locked_d = (run_d == RW'(LOCK_CNT));
        end else begin
          run_d    = '0;
          locked_d = 1'b0;
        end
      end
      armed_d   = 1'b1;
      timeout_d = 1'b0;
    end else if (cnt_d == CNT_MAX) begin
      timeout_d = 1'b1;
      armed_d   = 1'b0;
      run_d     = '0;
      locked_d  = 1'b0;
      match_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      armed_q   <= 1'b0;
      run_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      mv_q      <= 1'b0;
      match_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      armed_q   <= armed_d;
      run_q     <= run_d;
      period_q  <= period_d;
      high_q    <= high_d;
      mv_q      <= mv_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_hc  = period_q;
  assign high_hc    = high_q;
  assign meas_valid = mv_q;
  assign match      = match_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: divide-by-3 shapes, timeout, stale high, 2 hc period, reset pulse.
`timescale 1ns/1ps
module tb_clk_div_monitor;

  logic       clk;
  logic       reset;
  logic       div_in, div2;
  logic [7:0] period_hc, high_hc, period2, high2;
  logic       meas_valid, match, locked, timeout;
  logic       mv2, match2, locked2, timeout2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] period;
    logic [7:0] high;
    logic       match;
    logic       locked;
  } meas_t;

  meas_t mq[$];
  meas_t mon_m;

  clk_div_monitor #(.CW(8), .EXP_PERIOD(6), .EXP_HIGH(3), .LOCK_CNT(4)) u_dut (
    .clk(clk), .reset(reset), .div_in(div_in),
    .period_hc(period_hc), .high_hc(high_hc), .meas_valid(meas_valid),
    .match(match), .locked(locked), .timeout(timeout)
  );

  clk_div_monitor #(.CW(8), .EXP_PERIOD(2), .EXP_HIGH(1), .LOCK_CNT(4)) u_dut2 (
    .clk(clk), .reset(reset), .div_in(div2),
    .period_hc(period2), .high_hc(high2), .meas_valid(mv2),
    .match(match2), .locked(locked2), .timeout(timeout2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Record every measurement of the main instance, sampled just after posedge.
  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) begin
      mon_m.period = period_hc;
      mon_m.high   = high_hc;
      mon_m.match  = match;
      mon_m.locked = locked;
      mq.push_back(mon_m);
    end
  end

  task automatic hc(input logic v);
    @(clk);
    #2 div_in = v;
  endtask

  task automatic pattern(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      repeat (hi) hc(1'b1);
      repeat (lo) hc(1'b0);
    end
  endtask

  task automatic do_reset(input logic level);
    @(posedge clk);
    #2 reset = 1'b0;
    div_in = level;
    div2   = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    mq.delete();
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    div_in = 1'b0;
    div2   = 1'b0;
    #3 reset = 1'b0;
    #20;
    checks++; if (period_hc !== 8'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period_hc); end
    checks++; if (high_hc !== 8'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_hc); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_mv got %b exp 0", meas_valid); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", match); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
  endtask

  task automatic test_div3_50;
    do_reset(1'b0);
    repeat (4) hc(1'b0);
    pattern(5, 3, 3);
    repeat (4) hc(1'b0);
    checks++; if (mq.size() != 4) begin errors++; $display("FAIL d50_count got %0d exp 4", mq.size()); end
    foreach (mq[i]) begin
      checks++; if (mq[i].period !== 8'd6) begin errors++; $display("FAIL d50_period[%0d] got %0d exp 6", i, mq[i].period); end
      checks++; if (mq[i].high !== 8'd3) begin errors++; $display("FAIL d50_high[%0d] got %0d exp 3", i, mq[i].high); end
      checks++; if (mq[i].match !== 1'b1) begin errors++; $display("FAIL d50_match[%0d] got %b exp 1", i, mq[i].match); end
      checks++; if (mq[i].locked !== (i == 3)) begin errors++; $display("FAIL d50_locked[%0d] got %b exp %b", i, mq[i].locked, (i == 3)); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL d50_locked_live got %b exp 1", locked); end
    checks++; if (period_hc !== 8'd6) begin errors++; $display("FAIL d50_period_live got %0d exp 6", period_hc); end
  endtask

  task automatic test_div3_third;
    do_reset(1'b0);
    repeat (4) hc(1'b0);
    pattern(5, 2, 4);
    repeat (4) hc(1'b0);
    checks++; if (mq.size() != 4) begin errors++; $display("FAIL d33_count got %0d exp 4", mq.size()); end
    foreach (mq[i]) begin
      checks++; if (mq[i].period !== 8'd6) begin errors++; $display("FAIL d33_period[%0d] got %0d exp 6", i, mq[i].period); end
      checks++; if (mq[i].high !== 8'd2) begin errors++; $display("FAIL d33_high[%0d] got %0d exp 2", i, mq[i].high); end
      checks++; if (mq[i].match !== 1'b0) begin errors++; $display("FAIL d33_match[%0d] got %b exp 0", i, mq[i].match); end
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL d33_locked got %b exp 0", locked); end
  endtask

  task automatic test_timeout;
    int n;
    do_reset(1'b0);
    repeat (4) hc(1'b0);
    pattern(5, 3, 3);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL to_prelock got %b exp 1", locked); end
    repeat (220) hc(1'b0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", timeout); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL to_early_locked got %b exp 1", locked); end
    repeat (80) hc(1'b0);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", timeout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_locked got %b exp 0", locked); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL to_match got %b exp 0", match); end
    n = mq.size();
    pattern(1, 3, 3);
    checks++; if (mq.size() != n) begin errors++; $display("FAIL to_rearm_count got %0d exp %0d", mq.size(), n); end
    pattern(1, 3, 3);
    checks++; if (mq.size() != n + 1) begin errors++; $display("FAIL to_meas_count got %0d exp %0d", mq.size(), n + 1); end
    checks++; if (period_hc !== 8'd6) begin errors++; $display("FAIL to_period got %0d exp 6", period_hc); end
    checks++; if (high_hc !== 8'd3) begin errors++; $display("FAIL to_high got %0d exp 3", high_hc); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_relock got %b exp 0", locked); end
  endtask

  task automatic test_stale_high;
    do_reset(1'b1);
    repeat (5) hc(1'b1);
    repeat (3) hc(1'b0);
    pattern(1, 3, 3);
    checks++; if (mq.size() != 0) begin errors++; $display("FAIL stale_count got %0d exp 0", mq.size()); end
    pattern(1, 3, 3);
    checks++; if (mq.size() != 1) begin errors++; $display("FAIL stale_meas_count got %0d exp 1", mq.size()); end
    checks++; if (period_hc !== 8'd6) begin errors++; $display("FAIL stale_period got %0d exp 6", period_hc); end
    checks++; if (high_hc !== 8'd3) begin errors++; $display("FAIL stale_high got %0d exp 3", high_hc); end
  endtask

  task automatic test_period2;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2 div2 = 1'b1;
      @(negedge clk); #2 div2 = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (mv2 !== 1'b1) begin errors++; $display("FAIL p2_mv[%0d] got %b exp 1", i, mv2); end
      checks++; if (period2 !== 8'd2) begin errors++; $display("FAIL p2_period[%0d] got %0d exp 2", i, period2); end
      checks++; if (high2 !== 8'd1) begin errors++; $display("FAIL p2_high[%0d] got %0d exp 1", i, high2); end
      checks++; if (match2 !== 1'b1) begin errors++; $display("FAIL p2_match[%0d] got %b exp 1", i, match2); end
      #1 div2 = 1'b1;
      @(negedge clk); #2 div2 = 1'b0;
    end
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL p2_locked got %b exp 1", locked2); end
  endtask

  task automatic test_reset_pulse;
    do_reset(1'b0);
    repeat (4) hc(1'b0);
    pattern(5, 3, 3);
    repeat (2) hc(1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rp_prelock got %b exp 1", locked); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rp_locked got %b exp 0", locked); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL rp_match got %b exp 0", match); end
    checks++; if (period_hc !== 8'd0) begin errors++; $display("FAIL rp_period got %0d exp 0", period_hc); end
    checks++; if (high_hc !== 8'd0) begin errors++; $display("FAIL rp_high got %0d exp 0", high_hc); end
    #2 reset = 1'b1;
    mq.delete();
    repeat (2) hc(1'b0);
    pattern(4, 3, 3);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rp_early_lock got %b exp 0", locked); end
    checks++; if (mq.size() != 3) begin errors++; $display("FAIL rp_count4 got %0d exp 3", mq.size()); end
    pattern(1, 3, 3);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rp_relock got %b exp 1", locked); end
    checks++; if (mq.size() != 4) begin errors++; $display("FAIL rp_count5 got %0d exp 4", mq.size()); end
  endtask

  initial begin
    test_reset();
    test_div3_50();
    test_div3_third();
    test_timeout();
    test_stale_high();
    test_period2();
    test_reset_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
